// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared widths, dispatch op encodings and operand type for the Tomasulo core
package tomasulo_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAG_W  = 4;

    typedef enum logic [5:0] {
        OP_ADD  = 6'd0,
        OP_ADDI = 6'd1,
        OP_SUB  = 6'd2,
        OP_SLL  = 6'd3,
        OP_SRL  = 6'd4,
        OP_MUL  = 6'd5,
        OP_LW   = 6'd6,
        OP_SW   = 6'd7,
        OP_BNE  = 6'd8,
        OP_LI   = 6'd9
    } op_type_e;

    typedef struct packed {
        logic                  busy;
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_DATA_W-1:0] data;
    } operand_t;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational source-operand read with same-cycle commit bypass
module regfile_read_port
    import tomasulo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = 32,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int TAG_W    = DEF_TAG_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic [IDX_W-1:0]    rd_idx,
    input  logic [DATA_W-1:0]   values [NUM_REGS],
    input  logic [NUM_REGS-1:0] busy,
    input  logic [TAG_W-1:0]    tags [NUM_REGS],
    input  logic                commit_en,
    input  logic [IDX_W-1:0]    commit_idx,
    input  logic [TAG_W-1:0]    commit_tag,
    input  logic [DATA_W-1:0]   commit_data,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_busy,
    output logic [TAG_W-1:0]    rd_tag
);

    logic entry_busy;
    logic bypass_hit;
    logic is_zero;

    always_comb begin
        entry_busy = busy[rd_idx];
        is_zero    = ZERO_REG && (rd_idx == '0);
        // Only the commit that retires the current producer may forward.
        bypass_hit = commit_en && (commit_idx == rd_idx) && entry_busy
                     && (tags[rd_idx] == commit_tag);

        rd_data = values[rd_idx];
        rd_busy = entry_busy;
        rd_tag  = entry_busy ? tags[rd_idx] : '0;
        if (is_zero) begin
            rd_data = '0;
            rd_busy = 1'b0;
            rd_tag  = '0;
        end else if (bypass_hit) begin
            rd_data = commit_data;
            rd_busy = 1'b0;
            rd_tag  = '0;
        end
    end

endmodule

// File: rtl/tomasulo_regfile.sv
// rtl/tomasulo_regfile.sv - architectural register file with rename status table, commit and flush
module tomasulo_regfile
    import tomasulo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = 32,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int TAG_W    = DEF_TAG_W,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*IDX_W-1:0]  rdIdx,
    output logic [NUM_RD*DATA_W-1:0] rdData,
    output logic [NUM_RD-1:0]        rdBusy,
    output logic [NUM_RD*TAG_W-1:0]  rdTag,
    input  logic                     renameEn,
    input  logic [IDX_W-1:0]         renameIdx,
    input  logic [TAG_W-1:0]         renameTag,
    input  logic                     commitEn,
    input  logic [IDX_W-1:0]         commitIdx,
    input  logic [TAG_W-1:0]         commitTag,
    input  logic [DATA_W-1:0]        commitData,
    input  logic                     flush,
    output logic [IDX_W:0]           busyCount
);

    logic [DATA_W-1:0]   value_q [NUM_REGS];
    logic [DATA_W-1:0]   value_d [NUM_REGS];
    logic [TAG_W-1:0]    tag_q   [NUM_REGS];
    logic [TAG_W-1:0]    tag_d   [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [IDX_W:0]      busy_count_q;
    logic [IDX_W:0]      busy_count_d;

    logic commit_ok;
    logic rename_ok;

    always_comb begin
        commit_ok = commitEn && !(ZERO_REG && (commitIdx == '0));
        rename_ok = renameEn && !flush && !(ZERO_REG && (renameIdx == '0));

        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;

        // Value always written: in-order commit makes it the newest architectural value.
        if (commit_ok) begin
            value_d[commitIdx] = commitData;
            if (busy_q[commitIdx] && (tag_q[commitIdx] == commitTag)) begin
                busy_d[commitIdx] = 1'b0;
                tag_d[commitIdx]  = '0;
            end
        end

        if (flush) begin
            busy_d = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                tag_d[i] = '0;
            end
        end else if (rename_ok) begin
            busy_d[renameIdx] = 1'b1;
            tag_d[renameIdx]  = renameTag;
        end

        busy_count_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_count_d = busy_count_d + (IDX_W+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q       <= '0;
            busy_count_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
            value_q      <= value_d;
            tag_q        <= tag_d;
        end
    end

    assign busyCount = busy_count_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_read_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .IDX_W    (IDX_W),
            .TAG_W    (TAG_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .rd_idx      (rdIdx[k*IDX_W +: IDX_W]),
            .values      (value_q),
            .busy        (busy_q),
            .tags        (tag_q),
            .commit_en   (commitEn),
            .commit_idx  (commitIdx),
            .commit_tag  (commitTag),
            .commit_data (commitData),
            .rd_data     (rdData[k*DATA_W +: DATA_W]),
            .rd_busy     (rdBusy[k]),
            .rd_tag      (rdTag[k*TAG_W +: TAG_W])
        );
    end

endmodule

// File: tb/tb_tomasulo_regfile.sv
// tb/tb_tomasulo_regfile.sv - scoreboard bench for tomasulo_regfile with directed vectors
module tb_tomasulo_regfile;
    import tomasulo_pkg::*;

    localparam int IDX_W  = 5;
    localparam int NUM_RD = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_RD*IDX_W-1:0]  rdIdx;
    logic [NUM_RD*32-1:0]     rdData;
    logic [NUM_RD-1:0]        rdBusy;
    logic [NUM_RD*4-1:0]      rdTag;
    logic                     renameEn;
    logic [IDX_W-1:0]         renameIdx;
    logic [3:0]               renameTag;
    logic                     commitEn;
    logic [IDX_W-1:0]         commitIdx;
    logic [3:0]               commitTag;
    logic [31:0]              commitData;
    logic                     flush;
    logic [IDX_W:0]           busyCount;

    always #5 clk = ~clk;

    tomasulo_regfile dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rdIdx      (rdIdx),
        .rdData     (rdData),
        .rdBusy     (rdBusy),
        .rdTag      (rdTag),
        .renameEn   (renameEn),
        .renameIdx  (renameIdx),
        .renameTag  (renameTag),
        .commitEn   (commitEn),
        .commitIdx  (commitIdx),
        .commitTag  (commitTag),
        .commitData (commitData),
        .flush      (flush),
        .busyCount  (busyCount)
    );

    operand_t     exp0_q [$];
    operand_t     exp1_q [$];
    logic [5:0]   cnt_q  [$];
    string        name_q [$];
    logic         chk;
    int           n_checks;
    int           n_fail;

    operand_t     e0, e1, g0, g1;
    logic [5:0]   ec;
    string        nm;

    function automatic operand_t op(input logic b, input logic [3:0] t, input logic [31:0] d);
        operand_t r;
        r.busy = b;
        r.tag  = t;
        r.data = d;
        return r;
    endfunction

    // Monitor: pops one expectation whenever the bench marks the read outputs as presented.
    always @(negedge clk) begin
        if (chk) begin
            if (exp0_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: read presented with no expectation queued");
            end else begin
                e0 = exp0_q.pop_front();
                e1 = exp1_q.pop_front();
                ec = cnt_q.pop_front();
                nm = name_q.pop_front();
                g0 = op(rdBusy[0], rdTag[3:0], rdData[31:0]);
                g1 = op(rdBusy[1], rdTag[7:4], rdData[63:32]);
                n_checks++;
                if (g0 !== e0) begin
                    n_fail++;
                    $display("FAIL %s port0: got busy=%0b tag=%0d data=%h, expected busy=%0b tag=%0d data=%h",
                             nm, g0.busy, g0.tag, g0.data, e0.busy, e0.tag, e0.data);
                end
                n_checks++;
                if (g1 !== e1) begin
                    n_fail++;
                    $display("FAIL %s port1: got busy=%0b tag=%0d data=%h, expected busy=%0b tag=%0d data=%h",
                             nm, g1.busy, g1.tag, g1.data, e1.busy, e1.tag, e1.data);
                end
                n_checks++;
                if (busyCount !== ec) begin
                    n_fail++;
                    $display("FAIL %s busyCount: got %0d, expected %0d", nm, busyCount, ec);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        chk      = 1'b0;
        renameEn = 1'b0;
        commitEn = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        rdIdx = {b, a};
    endtask

    task automatic do_rename(input logic [4:0] idx, input logic [3:0] tag);
        renameEn  = 1'b1;
        renameIdx = idx;
        renameTag = tag;
    endtask

    task automatic do_commit(input logic [4:0] idx, input logic [3:0] tag, input logic [31:0] data);
        commitEn   = 1'b1;
        commitIdx  = idx;
        commitTag  = tag;
        commitData = data;
    endtask

    task automatic expect_rd(input string name, input operand_t x0, input operand_t x1, input int cnt);
        exp0_q.push_back(x0);
        exp1_q.push_back(x1);
        cnt_q.push_back(6'(cnt));
        name_q.push_back(name);
        chk = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        chk        = 1'b0;
        rst_n      = 1'b0;
        rdIdx      = '0;
        renameEn   = 1'b0;
        renameIdx  = '0;
        renameTag  = '0;
        commitEn   = 1'b0;
        commitIdx  = '0;
        commitTag  = '0;
        commitData = '0;
        flush      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        rd(5, 0);
        expect_rd("reset", op(0, 0, 0), op(0, 0, 0), 0);
        tick();

        do_rename(3, 7);
        tick();
        rd(3, 5);
        expect_rd("rename_r3", op(1, 7, 0), op(0, 0, 0), 1);
        tick();
        do_commit(3, 7, 32'h1234);
        rd(3, 3);
        expect_rd("bypass_r3", op(0, 0, 32'h1234), op(0, 0, 32'h1234), 1);
        tick();
        expect_rd("stored_r3", op(0, 0, 32'h1234), op(0, 0, 32'h1234), 0);
        tick();

        do_rename(4, 2);
        tick();
        do_rename(4, 5);
        tick();
        do_commit(4, 2, 32'hAA);
        rd(4, 3);
        expect_rd("stale_commit_no_bypass", op(1, 5, 0), op(0, 0, 32'h1234), 1);
        tick();
        expect_rd("stale_commit_value", op(1, 5, 32'hAA), op(0, 0, 32'h1234), 1);
        tick();
        do_commit(4, 5, 32'hBB);
        expect_rd("bypass_r4", op(0, 0, 32'hBB), op(0, 0, 32'h1234), 1);
        tick();
        expect_rd("stored_r4", op(0, 0, 32'hBB), op(0, 0, 32'h1234), 0);
        tick();

        do_rename(6, 1);
        tick();
        do_rename(6, 9);
        do_commit(6, 1, 32'h55);
        rd(6, 4);
        expect_rd("rename_commit_same_cycle_read", op(0, 0, 32'h55), op(0, 0, 32'hBB), 1);
        tick();
        expect_rd("rename_wins", op(1, 9, 32'h55), op(0, 0, 32'hBB), 1);
        tick();

        do_rename(1, 1);
        tick();
        do_rename(2, 2);
        tick();
        do_rename(7, 3);
        tick();
        rd(1, 7);
        expect_rd("pre_flush", op(1, 1, 0), op(1, 3, 0), 4);
        tick();
        flush = 1'b1;
        do_rename(8, 4);
        do_commit(2, 2, 32'h77);
        rd(2, 8);
        expect_rd("flush_cycle", op(0, 0, 32'h77), op(0, 0, 0), 4);
        tick();
        expect_rd("post_flush", op(0, 0, 32'h77), op(0, 0, 0), 0);
        tick();
        rd(6, 1);
        expect_rd("post_flush_r6_r1", op(0, 0, 32'h55), op(0, 0, 0), 0);
        tick();

        do_rename(0, 3);
        do_commit(0, 0, 32'hFFFF);
        rd(0, 0);
        expect_rd("zero_reg_same_cycle", op(0, 0, 0), op(0, 0, 0), 0);
        tick();
        expect_rd("zero_reg_after", op(0, 0, 0), op(0, 0, 0), 0);
        tick();

        do_rename(9, 6);
        tick();
        rd(9, 3);
        expect_rd("before_mid_reset", op(1, 6, 0), op(0, 0, 32'h1234), 1);
        tick();
        rst_n = 1'b0;
        do_rename(10, 8);
        do_commit(3, 0, 32'h99);
        tick();
        rst_n = 1'b1;
        rd(9, 3);
        expect_rd("mid_reset", op(0, 0, 0), op(0, 0, 0), 0);
        tick();
        rd(10, 3);
        expect_rd("mid_reset_rename_dropped", op(0, 0, 0), op(0, 0, 0), 0);
        tick();

        n_checks++;
        if (exp0_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp0_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/tomasulo_regfile.md
Name: tomasulo_regfile

Overview:
Parametrised architectural register file with an integrated register-status (rename) table for the Tomasulo core. Each register holds a committed value plus a busy bit and the ROB tag of its pending producer. Dispatch reads source operands as either a value or a ROB tag, and renames the destination. The ROB commit port writes back values and clears status only when the tag matches. A flush port discards all renames on mispredict.

Parameters:
DATA_W, 32, register data width
NUM_REGS, 32, number of architectural registers (power of two)
IDX_W, $clog2(NUM_REGS), register index width (derived)
TAG_W, 4, ROB tag width (ROB depth = 2**TAG_W)
NUM_RD, 2, number of independent source read ports
ZERO_REG, 1, 1 = register 0 always reads 0, is never written and never renamed

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous reset, active low
rdIdx  in  NUM_RD*IDX_W  packed source indices, port k at [k*IDX_W +: IDX_W]
rdData  out  NUM_RD*DATA_W  value per port, meaningful when rdBusy[k]=0
rdBusy  out  NUM_RD  1 = operand pending; wait on rdTag
rdTag  out  NUM_RD*TAG_W  producing ROB tag per port, 0 when not busy
renameEn  in  1  dispatch claims a destination this cycle
renameIdx  in  IDX_W  destination register
renameTag  in  TAG_W  ROB tag allocated to the destination
commitEn  in  1  ROB retires a register-writing instruction
commitIdx  in  IDX_W  retiring destination
commitTag  in  TAG_W  ROB tag of the retiring entry
commitData  in  DATA_W  retiring value
flush  in  1  discard all speculative renames
busyCount  out  IDX_W+1  number of registers currently busy

Behaviour:
- Reset (rst_n=0 at a rising edge): all values = 0, all busy = 0, all tags = 0, busyCount = 0. Reset overrides rename, commit and flush in the same cycle.
- Read ports are combinational from current state, with a same-cycle commit bypass.
  - If commitEn, commitIdx==rdIdx[k], busy[idx] set and tag[idx]==commitTag: rdData=commitData, rdBusy=0, rdTag=0.
  - Otherwise output the stored value, busy bit and tag. rdTag is 0 when not busy.
  - With ZERO_REG=1, idx 0 always gives 0 / not busy.
- Reads in a cycle never see that cycle's rename. Sources are read before the destination is renamed, so "add r3,r3,r1" reads the old r3 status.
- Commit (registered): when commitEn, value[commitIdx] <= commitData unconditionally, because in-order commit makes this the newest architectural value.
  - busy[commitIdx] clears only if tag[commitIdx]==commitTag.
  - On a mismatch a younger rename exists, and busy/tag are kept.
- Rename (registered): when renameEn and not flush, busy[renameIdx] <= 1 and tag[renameIdx] <= renameTag. Re-renaming a busy register overwrites its tag.
- Rename and commit to the same register in the same cycle: value written, rename wins (busy=1, tag=renameTag), regardless of tag match.
- Flush: busy[all] <= 0 and tag[all] <= 0 next cycle. A commit in the same cycle still writes its value. A rename in the same cycle is dropped.
- ZERO_REG=1: writes and renames to index 0 are ignored.
- busyCount is a register updated every cycle. It equals the number of set busy bits after the edge, and is consistent with the status array one cycle after any event.
- Index fields are always in range (power-of-two NUM_REGS), so no out-of-range handling is needed.

Decomposition:
- Shared package tomasulo_pkg holds:
  - DATA_W and TAG_W defaults;
  - the operator-type encodings (add/addi/sub/sll/srl/mul/lw/sw/bne/li, 6-bit) used by dispatch;
  - a typedef operand_t {busy, tag, data} for the read-port result.
- One natural sub-module, regfile_read_port: a single combinational read with the commit bypass, instantiated NUM_RD times in a generate loop.
- Status array, value array and busyCount stay in the top level.

Test Plan:
- Reset, then read r5 and r0 → rdData=0, rdBusy=0, rdTag=0, busyCount=0.
- Rename r3 tag 7; next cycle read r3 → rdBusy=1, rdTag=7, busyCount=1. Commit r3 tag 7 data 0x1234; same cycle read r3 → bypass gives data 0x1234, busy 0. Next cycle: stored 0x1234, busyCount=0.
- Rename r4 tag 2, then rename r4 tag 5; commit r4 tag 2 data 0xAA → value 0xAA, r4 still busy with tag 5, and bypass not taken (read shows busy, tag 5). Commit r4 tag 5 data 0xBB → value 0xBB, not busy.
- Same cycle: rename r6 tag 9 and commit r6 tag 1 data 0x55 → r6 value 0x55, busy 1, tag 9.
- Rename r1/r2/r7 with tags 1/2/3, then flush together with renameEn r8 tag 4 and commit r2 tag 2 data 0x77 → all busy clear, busyCount=0, r2=0x77, r8 not renamed.
- ZERO_REG=1: rename r0 tag 3 and commit r0 data 0xFFFF → r0 reads 0, not busy. Also pulse rst_n low mid-sequence with renameEn high → all state zero after the edge.
